mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control sequencer for the 16-bit CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the one-cycle `pc_update` strobe and `pc_src` select into the program-counter register, and handshakes with instruction and data memory. It also pulses the IR, register-file and output-port write enables, and counts retired instructions. Decode is external: the controller receives one-hot instruction-class flags.

## Interface
- `WORD_SIZE`, 16, width of `num_inst`
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; while high, all outputs read 0
- `is_alu`, `is_load`, `is_store`, `is_branch`, `is_jump`, `is_jump_reg`, `is_wwd`, `is_halt`  in  1 each  instruction-class flags, valid from ID onward
- `is_link`  in  1  jump also writes the return address (JAL/JRL)
- `branch_taken`  in  1  ALU branch condition, valid in EX
- `i_ready`, `d_ready`  in  1  memory access complete this cycle
- `i_read_req`, `d_read_req`, `d_write_req`  out  1  memory requests
- `ir_write`  out  1  latch the fetched word into IR
- `pc_update`  out  1  PC write enable, one-cycle strobe
- `pc_src`  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target, 3 = register
- `reg_write`, `link_write`, `wwd_en`  out  1  register-file write, link write, output-port write
- `inst_done`  out  1  pulses when an instruction retires
- `is_halted`  out  1  high in HALT
- `num_inst`  out  WORD_SIZE  count of retired instructions
- `state`  out  3  current state, for debug

## Operation
- States: BOOT, IF, ID, EX, MEM, WB, HALT.
- Reset edge: state goes to BOOT and `num_inst` goes to 0.
- BOOT (one cycle):
  - `pc_update`=1, `pc_src`=0, which moves the PC from its reset value −1 to 0.
  - No `inst_done`. Next state: IF.
- IF:
  - `i_read_req` stays high until `i_ready` is sampled.
  - In the `i_ready` cycle, `ir_write`=1 and the next state is ID. Zero-wait memory is legal.
- ID, class priority halt > jump/jump_reg > wwd > other:
  - halt → HALT. Retires; no PC update.
  - jump → `pc_update`, `pc_src`=2 (3 if `is_jump_reg`), `link_write`=`is_link`. Retires; next state IF.
  - wwd → `wwd_en`, `pc_update`, `pc_src`=0. Retires; next state IF.
  - otherwise → EX.
- EX, priority branch > load/store > alu:
  - branch → `pc_update`, `pc_src`=`branch_taken`?1:0. Retires; next state IF.
  - load/store → MEM.
  - alu → WB.
  - no flag set → NOP: `pc_update`, `pc_src`=0. Retires; next state IF.
- MEM:
  - `d_read_req` (load) or `d_write_req` (store) stays high until `d_ready`.
  - On `d_ready`: load → WB; store → `pc_update`, `pc_src`=0, retires, next state IF.
- WB: `reg_write`=1, `pc_update`, `pc_src`=0. Retires; next state IF.
- HALT: absorbing until reset. `is_halted`=1; all other strobes 0.
- Retire: `inst_done`=1 for one cycle and `num_inst` += 1, wrapping from 0xFFFF to 0x0000.
- When `pc_update`=0, `pc_src` reads 0.

## Timing
- All strobes are combinational from the state register and the current-cycle inputs. The datapath samples them at the next rising edge.
- `pc_update` is high for exactly one cycle per retired non-halt instruction, plus once in BOOT. It is never high for two consecutive cycles.
- Minimum cycles per instruction, counted from IF entry with zero-wait memory:
  - jump / wwd / halt: 2
  - branch / NOP: 3
  - alu / store: 4
  - load: 5
- Each memory wait cycle adds 1 cycle. Requests stay asserted and stable while waiting.
- Reset high in any state, including mid-wait in IF or MEM:
  - Requests and strobes drop in that same cycle.
  - BOOT follows the reset edge; no partial retire is counted.
- `i_ready`/`d_ready` asserted outside a matching request state: ignored.
- `num_inst` updates on the edge that ends the retiring cycle.

## Test plan
- Reset, then release: BOOT has `pc_update`=1, `pc_src`=0. Next cycle, IF has `i_read_req`=1 and `num_inst`=0.
- ALU instruction, zero wait: states IF, ID, EX, WB. WB has `reg_write`=1 and `pc_update`=1. `num_inst` goes 0→1 after 4 cycles.
- Load with `i_ready` delayed 2 cycles and `d_ready` delayed 3 cycles: retires after 10 cycles. Requests are held stable throughout; exactly one `pc_update`.
- Branch with `branch_taken`=1, then 0: `pc_src`=1, then 0, each in EX. JRL: `pc_src`=3 and `link_write`=1 in ID.
- HALT: after IF and ID, `is_halted`=1 and `num_inst` has incremented. Further `i_ready` pulses produce no strobes.
- Reset asserted mid-MEM wait: `d_read_req` drops the same cycle, the next state is BOOT, and `num_inst`=0. Separately, preload 0xFFFF retirements and retire one more: `num_inst` wraps to 0x0000.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer for the 16-bit CPU datapath.
// Steps each instruction through IF/ID/EX/MEM/WB. It handshakes with the
// instruction and data memories, strobes the PC, IR, register-file and
// output-port writes, and counts retired instructions.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   is_* / is_link       - one-hot instruction-class flags from external decode
//   branch_taken         - ALU branch condition, sampled in EX
//   i_ready / d_ready    - memory access completes this cycle
//   i_read_req, d_read_req, d_write_req - memory requests
//   ir_write, pc_update, pc_src, reg_write, link_write, wwd_en - datapath strobes
//   inst_done, is_halted - retire pulse, halted flag
//   num_inst             - retired instruction count (wraps)
//   state                - current state, for debug
module mc_control_fsm #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_alu,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 is_branch,
  input  logic                 is_jump,
  input  logic                 is_jump_reg,
  input  logic                 is_wwd,
  input  logic                 is_halt,
  input  logic                 is_link,
  input  logic                 branch_taken,
  input  logic                 i_ready,
  input  logic                 d_ready,
  output logic                 i_read_req,
  output logic                 d_read_req,
  output logic                 d_write_req,
  output logic                 ir_write,
  output logic                 pc_update,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 link_write,
  output logic                 wwd_en,
  output logic                 inst_done,
  output logic                 is_halted,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [2:0]           state
);

  localparam int unsigned STATE_W = 3;

  localparam logic [1:0] SRC_PC1    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_REG    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_BOOT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic                   mem_load_q, mem_load_d;  // MEM access is a load (else store)
  logic [WORD_SIZE-1:0]   num_inst_q;
  logic                   retire_c;

  // State, MEM direction and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      mem_load_q <= 1'b0;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_load_q <= mem_load_d;
      if (retire_c) begin
        num_inst_q <= num_inst_q + WORD_SIZE'(1);
      end
    end
  end

  // Next state and strobes from current state and inputs
  always_comb begin
    state_d     = state_q;
    mem_load_d  = mem_load_q;
    retire_c    = 1'b0;
    i_read_req  = 1'b0;
    d_read_req  = 1'b0;
    d_write_req = 1'b0;
    ir_write    = 1'b0;
    pc_update   = 1'b0;
    pc_src      = SRC_PC1;
    reg_write   = 1'b0;
    link_write  = 1'b0;
    wwd_en      = 1'b0;
    is_halted   = 1'b0;

    case (state_q)
      // PC leaves its reset value (-1) and lands on 0
      S_BOOT: begin
        pc_update = 1'b1;
        state_d   = S_IF;
      end

      S_IF: begin
        i_read_req = 1'b1;
        if (i_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end

      // halt > jump/jump_reg > wwd > everything else
      S_ID: begin
        if (is_halt) begin
          retire_c = 1'b1;
          state_d  = S_HALT;
        end else if (is_jump || is_jump_reg) begin
          pc_update  = 1'b1;
          pc_src     = is_jump_reg ? SRC_REG : SRC_JUMP;
          link_write = is_link;
          retire_c   = 1'b1;
          state_d    = S_IF;
        end else if (is_wwd) begin
          wwd_en    = 1'b1;
          pc_update = 1'b1;
          retire_c  = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      // branch > load/store > alu; no flag set retires as a NOP
      S_EX: begin
        if (is_branch) begin
          pc_update = 1'b1;
          pc_src    = branch_taken ? SRC_BRANCH : SRC_PC1;
          retire_c  = 1'b1;
          state_d   = S_IF;
        end else if (is_load || is_store) begin
          mem_load_d = is_load;
          state_d    = S_MEM;
        end else if (is_alu) begin
          state_d = S_WB;
        end else begin
          pc_update = 1'b1;
          retire_c  = 1'b1;
          state_d   = S_IF;
        end
      end

      // Direction is latched in EX so the request stays stable while waiting
      S_MEM: begin
        d_read_req  = mem_load_q;
        d_write_req = !mem_load_q;
        if (d_ready) begin
          if (mem_load_q) begin
            state_d = S_WB;
          end else begin
            pc_update = 1'b1;
            retire_c  = 1'b1;
            state_d   = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_update = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_IF;
      end

      S_HALT: begin
        is_halted = 1'b1;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    inst_done = retire_c;

    // Reset silences every output in the same cycle
    if (reset) begin
      i_read_req  = 1'b0;
      d_read_req  = 1'b0;
      d_write_req = 1'b0;
      ir_write    = 1'b0;
      pc_update   = 1'b0;
      pc_src      = SRC_PC1;
      reg_write   = 1'b0;
      link_write  = 1'b0;
      wwd_en      = 1'b0;
      inst_done   = 1'b0;
      is_halted   = 1'b0;
    end
  end

  assign num_inst = reset ? '0 : num_inst_q;
  assign state    = reset ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and random instructions checked
// cycle by cycle against a cycle-count/strobe model derived from the
// instruction class, memory wait counts and retire rules.
module tb_mc_control_fsm;

  localparam int C_HALT   = 0;
  localparam int C_JUMP   = 1;
  localparam int C_WWD    = 2;
  localparam int C_BRANCH = 3;
  localparam int C_LOAD   = 4;
  localparam int C_STORE  = 5;
  localparam int C_ALU    = 6;
  localparam int C_NOP    = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fl = 8'h00;  // [0]alu [1]load [2]store [3]branch [4]jump [5]jump_reg [6]wwd [7]halt
  logic        is_link = 1'b0;
  logic        branch_taken = 1'b0;
  logic        i_ready = 1'b0;
  logic        d_ready = 1'b0;

  logic        i_read_req, d_read_req, d_write_req, ir_write, pc_update;
  logic [1:0]  pc_src;
  logic        reg_write, link_write, wwd_en, inst_done, is_halted;
  logic [15:0] num_inst;
  logic [2:0]  state;

  // Narrow-counter instance used to exercise counter wrap quickly
  logic        s_i_read_req, s_d_read_req, s_d_write_req, s_ir_write, s_pc_update;
  logic [1:0]  s_pc_src;
  logic        s_reg_write, s_link_write, s_wwd_en, s_inst_done, s_is_halted;
  logic [3:0]  s_num;
  logic [2:0]  s_state;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_cnt = 16'h0;

  always #5 clk = ~clk;

  mc_control_fsm #(.WORD_SIZE(16)) u_dut (
    .clk(clk), .reset(reset),
    .is_alu(fl[0]), .is_load(fl[1]), .is_store(fl[2]), .is_branch(fl[3]),
    .is_jump(fl[4]), .is_jump_reg(fl[5]), .is_wwd(fl[6]), .is_halt(fl[7]),
    .is_link(is_link), .branch_taken(branch_taken),
    .i_ready(i_ready), .d_ready(d_ready),
    .i_read_req(i_read_req), .d_read_req(d_read_req), .d_write_req(d_write_req),
    .ir_write(ir_write), .pc_update(pc_update), .pc_src(pc_src),
    .reg_write(reg_write), .link_write(link_write), .wwd_en(wwd_en),
    .inst_done(inst_done), .is_halted(is_halted), .num_inst(num_inst), .state(state)
  );

  mc_control_fsm #(.WORD_SIZE(4)) u_small (
    .clk(clk), .reset(reset),
    .is_alu(fl[0]), .is_load(fl[1]), .is_store(fl[2]), .is_branch(fl[3]),
    .is_jump(fl[4]), .is_jump_reg(fl[5]), .is_wwd(fl[6]), .is_halt(fl[7]),
    .is_link(is_link), .branch_taken(branch_taken),
    .i_ready(i_ready), .d_ready(d_ready),
    .i_read_req(s_i_read_req), .d_read_req(s_d_read_req), .d_write_req(s_d_write_req),
    .ir_write(s_ir_write), .pc_update(s_pc_update), .pc_src(s_pc_src),
    .reg_write(s_reg_write), .link_write(s_link_write), .wwd_en(s_wwd_en),
    .inst_done(s_inst_done), .is_halted(s_is_halted), .num_inst(s_num), .state(s_state)
  );

  // Effective class after decode priority
  function automatic int eff_class(input logic [7:0] f);
    if (f[7])              return C_HALT;
    else if (f[4] || f[5]) return C_JUMP;
    else if (f[6])         return C_WWD;
    else if (f[3])         return C_BRANCH;
    else if (f[1])         return C_LOAD;
    else if (f[2])         return C_STORE;
    else if (f[0])         return C_ALU;
    else                   return C_NOP;
  endfunction

  // Zero-wait cycles per instruction from IF entry
  function automatic int base_cycles(input int cls);
    case (cls)
      C_HALT, C_JUMP, C_WWD: return 2;
      C_BRANCH, C_NOP:       return 3;
      C_ALU, C_STORE:        return 4;
      default:               return 5;
    endcase
  endfunction

  function automatic int inst_cycles(input int cls, input int iw, input int dw);
    return base_cycles(cls) + iw + (((cls == C_LOAD) || (cls == C_STORE)) ? dw : 0);
  endfunction

  // Expected {i_rd, d_rd, d_wr, ir_wr, pc_upd, pc_src, reg_wr, link_wr, wwd, done, halted}
  function automatic logic [11:0] exp_vec(input int cls, input logic jr, input logic tk,
                                          input logic lnk, input int iw, input int dw,
                                          input int c);
    int         n;
    logic       last, pcu, dreq, dwr, regw, lw, ww;
    logic [1:0] src;
    n    = inst_cycles(cls, iw, dw);
    last = (c == n - 1);
    pcu  = last && (cls != C_HALT);
    dreq = (cls == C_LOAD)  && (c >= iw + 3) && (c <= iw + 3 + dw);
    dwr  = (cls == C_STORE) && (c >= iw + 3) && (c <= iw + 3 + dw);
    regw = last && ((cls == C_ALU) || (cls == C_LOAD));
    lw   = last && (cls == C_JUMP) && lnk;
    ww   = last && (cls == C_WWD);
    src  = 2'd0;
    if (cls == C_JUMP) src = jr ? 2'd3 : 2'd2;
    else if ((cls == C_BRANCH) && tk) src = 2'd1;
    return {(c <= iw), dreq, dwr, (c == iw), pcu, (pcu ? src : 2'd0), regw, lw, ww, last, 1'b0};
  endfunction

  function automatic logic [31:0] obs();
    return {i_read_req, d_read_req, d_write_req, ir_write, pc_update, pc_src,
            reg_write, link_write, wwd_en, inst_done, is_halted, num_inst, s_num};
  endfunction

  function automatic logic [31:0] with_cnt(input logic [11:0] v);
    return {v, model_cnt, 4'(model_cnt)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; i_ready = 1'b1; d_ready = 1'b1;
    #1 chk("reset0", obs(), 32'h0);
    @(negedge clk);
    #1 chk("reset1", obs(), 32'h0);
    @(negedge clk); reset = 1'b0; model_cnt = 16'h0;
    #1 chk("boot", obs(), with_cnt(12'h080));
  endtask

  // One instruction; abort_c >= 0 asserts reset in that cycle instead
  task automatic run_inst(input logic [7:0] f, input logic lnk, input logic tk,
                          input int iw, input int dw, input int abort_c, input string name);
    int cls, n, icnt, dcnt;
    cls  = eff_class(f);
    n    = inst_cycles(cls, iw, dw);
    icnt = 0;
    dcnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        fl = f; is_link = lnk; branch_taken = tk;
      end
      if (c == abort_c) begin
        reset = 1'b1;
        #1 chk($sformatf("%s abort", name), obs(), 32'h0);
        @(negedge clk); reset = 1'b0; model_cnt = 16'h0;
        #1 chk($sformatf("%s boot", name), obs(), with_cnt(12'h080));
        return;
      end
      i_ready = i_read_req ? (icnt == iw) : 1'($urandom_range(0, 1));
      d_ready = (d_read_req || d_write_req) ? (dcnt == dw) : 1'($urandom_range(0, 1));
      if (i_read_req) icnt++;
      if (d_read_req || d_write_req) dcnt++;
      #1 chk($sformatf("%s c%0d", name, c), obs(),
             with_cnt(exp_vec(cls, f[5], tk, lnk, iw, dw, c)));
    end
    model_cnt = model_cnt + 16'd1;
  endtask

  task automatic halt_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      i_ready = 1'b1;
      d_ready = 1'($urandom_range(0, 1));
      #1 chk($sformatf("halted c%0d", c), obs(), with_cnt(12'h001));
    end
  endtask

  task automatic run_random(input int count);
    logic [7:0] f;
    int         k;
    for (int i = 0; i < count; i++) begin
      f = 8'h00;
      k = $urandom_range(0, 7);
      if (k < 7) f[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 6);
        f[k] = 1'b1;
      end
      if (f[1] && f[2]) f[2] = 1'b0;
      run_inst(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3), -1, $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    do_reset();
    run_inst(8'h01, 1'b0, 1'b0, 0, 0, -1, "alu");
    run_inst(8'h02, 1'b0, 1'b0, 2, 3, -1, "load_wait");
    run_inst(8'h08, 1'b0, 1'b1, 0, 0, -1, "br_taken");
    run_inst(8'h08, 1'b0, 1'b0, 1, 0, -1, "br_not");
    run_inst(8'h20, 1'b1, 1'b0, 0, 0, -1, "jrl");
    run_inst(8'h10, 1'b1, 1'b0, 1, 0, -1, "jal");
    run_inst(8'h10, 1'b0, 1'b0, 0, 0, -1, "jmp");
    run_inst(8'h40, 1'b0, 1'b0, 0, 0, -1, "wwd");
    run_inst(8'h04, 1'b0, 1'b0, 1, 2, -1, "store");
    run_inst(8'h00, 1'b0, 1'b1, 0, 0, -1, "nop");
    run_inst(8'h48, 1'b0, 1'b1, 0, 0, -1, "wwd_over_br");
    run_inst(8'h1A, 1'b0, 1'b1, 0, 0, -1, "jump_over_all");
    run_inst(8'h0B, 1'b0, 1'b0, 0, 1, -1, "br_over_load");
    run_random(48);

    // Reset during the second MEM wait cycle of a load
    run_inst(8'h02, 1'b0, 1'b0, 0, 3, 4, "load_abort");
    run_random(20);

    run_inst(8'h80, 1'b0, 1'b0, 1, 0, -1, "halt");
    halt_idle(4);
    do_reset();
    run_inst(8'h01, 1'b0, 1'b0, 0, 0, -1, "alu_after_halt");
    run_inst(8'hD9, 1'b1, 1'b1, 0, 0, -1, "halt_prio");
    halt_idle(2);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
